// File: rtl/bitmap_packer.sv
// Collects a stream of bit indices into a WIDTH-bit occupancy bitmap and
// releases one dense mask (with popcount and error flag) per group.
module bitmap_packer #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned ADDR_W = $clog2(WIDTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [ADDR_W-1:0]   in_addr,
    input  logic                in_last,
    input  logic                in_flush,
    output logic                in_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_mask,
    output logic [ADDR_W:0]     out_count,
    output logic                out_has_ones,
    output logic                out_err
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mask_q, mask_d;
    logic               err_q, err_d;
    logic [WIDTH-1:0]   set_vec, merged_mask;
    logic               bad_addr, merged_err, close;
    logic [CNT_W-1:0]   merged_count;
    logic [WIDTH-1:0]   out_mask_d;
    logic [CNT_W-1:0]   out_count_d;
    logic               out_has_ones_d, out_err_d;

    // Decode the incoming index into a one-hot set vector; out-of-range
    // indices set nothing and only flag the group.
    always_comb begin
        set_vec  = '0;
        bad_addr = (32'(in_addr) >= WIDTH);
        for (int unsigned i = 0; i < WIDTH; i++) begin
            set_vec[i] = in_valid && (32'(in_addr) == i);
        end
        merged_mask = mask_q | set_vec;
        merged_err  = err_q | (in_valid & bad_addr);
    end

    always_comb begin
        merged_count = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            merged_count = merged_count + CNT_W'(merged_mask[i]);
        end
    end

    always_comb begin
        state_d        = state_q;
        mask_d         = mask_q;
        err_d          = err_q;
        out_mask_d     = out_mask;
        out_count_d    = out_count;
        out_has_ones_d = out_has_ones;
        out_err_d      = out_err;
        close          = 1'b0;
        case (state_q)
            ACCUM: begin
                close  = (in_valid & in_last) | in_flush;
                mask_d = merged_mask;
                err_d  = merged_err;
                if (close) begin
                    out_mask_d     = merged_mask;
                    out_count_d    = merged_count;
                    out_has_ones_d = |merged_mask;
                    out_err_d      = merged_err;
                    mask_d         = '0;
                    err_d          = 1'b0;
                    state_d        = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) state_d = ACCUM;
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ACCUM;
            mask_q       <= '0;
            err_q        <= 1'b0;
            out_mask     <= '0;
            out_count    <= '0;
            out_has_ones <= 1'b0;
            out_err      <= 1'b0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            err_q        <= err_d;
            out_mask     <= out_mask_d;
            out_count    <= out_count_d;
            out_has_ones <= out_has_ones_d;
            out_err      <= out_err_d;
        end
    end

    // Handshake flags are pure decodes of the state register.
    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == HOLD);

endmodule
